// File: rtl/ask_modulator.sv
// ask_modulator: byte-serial amplitude-shift-keyed carrier generator.
// A byte is accepted in IDLE and sent MSB first. Each bit is held for
// BIT_DIV clocks as a square carrier whose amplitude selects the bit value.
// A BIT_DIV-clock silent GAP follows, then the block returns to IDLE.
// Optional feature macro: ASK_PREAMBLE_EN. When it is defined, the byte
// 8'hAA is sent in the PRE state ahead of every data byte.
//
// Handshake: data_in is taken on a rising edge where data_valid and
// data_ready are both 1. data_ready is 1 only in IDLE. When data_valid is
// high at any other time, the input is ignored and nothing is queued.

module ask_modulator #(
    parameter int                    IO_width     = 14,
    parameter int                    BIT_DIV      = 1000,
    parameter logic [15:0]           CARRIER_STEP = 16'd4096,
    parameter logic [IO_width-1:0]   AMP_HIGH     = 14'd5500,
    parameter logic [IO_width-1:0]   AMP_LOW      = 14'd100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic                       busy,
    output logic signed [IO_width-1:0] ASK_out,
    output logic signed [IO_width-1:0] env_out,
    output logic [1:0]                 state_dbg_o
);

    localparam int CNT_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
`ifdef ASK_PREAMBLE_EN
        ,
        PRE  = 2'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [15:0]           phase_q, phase_d;
    logic [IO_width-1:0]   ask_q, ask_d;
    logic [IO_width-1:0]   env_q, env_d;
`ifdef ASK_PREAMBLE_EN
    logic [7:0]            data_q, data_d;
`endif

    logic [IO_width-1:0]   amp;
    logic                  sym_end;

    assign amp     = shift_q[7] ? AMP_HIGH : AMP_LOW;
    assign sym_end = (cnt_q == CNT_LAST);

    assign data_ready  = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ASK_out     = ask_q;
    assign env_out     = env_q;
    assign state_dbg_o = state_q;

    // Next-state, counters, shift register, phase and the next output sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        phase_d = phase_q;
        ask_d   = '0;
        env_d   = '0;
`ifdef ASK_PREAMBLE_EN
        data_d  = data_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    phase_d = 16'd0;
`ifdef ASK_PREAMBLE_EN
                    // The data byte waits in data_q while the preamble shifts out.
                    shift_d = 8'hAA;
                    data_d  = data_in;
                    state_d = PRE;
`else
                    shift_d = data_in;
                    state_d = DATA;
`endif
                end
            end
`ifdef ASK_PREAMBLE_EN
            PRE: begin
                ask_d   = phase_q[15] ? -amp : amp;
                env_d   = amp;
                phase_d = phase_q + CARRIER_STEP;
                cnt_d   = cnt_q + CNT_W'(1);
                if (sym_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        // The phase keeps running into DATA. Only the bit source changes.
                        bit_d   = 3'd0;
                        shift_d = data_q;
                        state_d = DATA;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
`endif
            DATA: begin
                ask_d   = phase_q[15] ? -amp : amp;
                env_d   = amp;
                phase_d = phase_q + CARRIER_STEP;
                cnt_d   = cnt_q + CNT_W'(1);
                if (sym_end) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = GAP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sym_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            phase_q <= 16'd0;
            ask_q   <= '0;
            env_q   <= '0;
`ifdef ASK_PREAMBLE_EN
            data_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            phase_q <= phase_d;
            ask_q   <= ask_d;
            env_q   <= env_d;
`ifdef ASK_PREAMBLE_EN
            data_q  <= data_d;
`endif
        end
    end

endmodule
